// File: rtl/arp_request_parser.sv
// ARP request parser: watches an MII receive stream, validates an Ethernet/ARP
// request addressed to this board and publishes the sender MAC/IP with a
// one-cycle ena pulse once the frame has ended.
module arp_request_parser #(
  parameter bit ACCEPT_BROADCAST = 1'b1
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        rx_dv,
  input  logic [3:0]  rxd,
  input  logic [47:0] BOARD_MAC,
  input  logic [31:0] BOARD_IP,
  input  logic        tx_busy,
  output logic [47:0] PC_MAC,
  output logic [31:0] PC_IP,
  output logic        ena,
  output logic [7:0]  arp_hits
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_DATA, S_WAIT_END, S_DROP, S_PUBLISH
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  lo_q, lo_d;
  logic        uni_ok_q, uni_ok_d;
  logic        bc_ok_q, bc_ok_d;
  logic [47:0] smac_q, smac_d;
  logic [31:0] sip_q, sip_d;
  logic [47:0] pc_mac_q, pc_mac_d;
  logic [31:0] pc_ip_q, pc_ip_d;
  logic        ena_q, ena_d;
  logic [7:0]  hits_q, hits_d;
  logic        armed_q, armed_d;

  logic [7:0]  rx_byte;
  logic [7:0]  mac_byte;
  logic [7:0]  exp_byte;
  logic        chk;
  logic        in_dmac;
  logic        uni_ok_n, bc_ok_n;
  logic        byte_bad;

  assign rx_byte = {rxd, lo_q};
  assign in_dmac = (cnt_q < 6'd6);

  // Expected value for the byte currently completing (dest MAC and fixed fields)
  always_comb begin
    mac_byte = '0;
    exp_byte = '0;
    chk      = 1'b0;
    case (cnt_q)
      6'd0:  mac_byte = BOARD_MAC[47:40];
      6'd1:  mac_byte = BOARD_MAC[39:32];
      6'd2:  mac_byte = BOARD_MAC[31:24];
      6'd3:  mac_byte = BOARD_MAC[23:16];
      6'd4:  mac_byte = BOARD_MAC[15:8];
      6'd5:  mac_byte = BOARD_MAC[7:0];
      6'd12: begin chk = 1'b1; exp_byte = 8'h08; end
      6'd13: begin chk = 1'b1; exp_byte = 8'h06; end
      6'd14: begin chk = 1'b1; exp_byte = 8'h00; end
      6'd15: begin chk = 1'b1; exp_byte = 8'h01; end
      6'd16: begin chk = 1'b1; exp_byte = 8'h08; end
      6'd17: begin chk = 1'b1; exp_byte = 8'h00; end
      6'd18: begin chk = 1'b1; exp_byte = 8'h06; end
      6'd19: begin chk = 1'b1; exp_byte = 8'h04; end
      6'd20: begin chk = 1'b1; exp_byte = 8'h00; end
      6'd21: begin chk = 1'b1; exp_byte = 8'h01; end
      6'd38: begin chk = 1'b1; exp_byte = BOARD_IP[31:24]; end
      6'd39: begin chk = 1'b1; exp_byte = BOARD_IP[23:16]; end
      6'd40: begin chk = 1'b1; exp_byte = BOARD_IP[15:8]; end
      6'd41: begin chk = 1'b1; exp_byte = BOARD_IP[7:0]; end
      default: ;
    endcase
  end

  // Dest MAC must match entirely as unicast or entirely as broadcast, so each
  // alternative is tracked separately across bytes 0-5.
  always_comb begin
    uni_ok_n = uni_ok_q && (rx_byte == mac_byte);
    bc_ok_n  = bc_ok_q && (rx_byte == 8'hFF) && (ACCEPT_BROADCAST == 1'b1);
    byte_bad = in_dmac ? !(uni_ok_n || bc_ok_n) : (chk && (rx_byte != exp_byte));
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    lo_d     = lo_q;
    uni_ok_d = uni_ok_q;
    bc_ok_d  = bc_ok_q;
    smac_d   = smac_q;
    sip_d    = sip_q;
    pc_mac_d = pc_mac_q;
    pc_ip_d  = pc_ip_q;
    ena_d    = 1'b0;
    hits_d   = hits_q;
    armed_d  = armed_q | ~rx_dv;

    case (state_q)
      S_IDLE: begin
        // armed_q blocks a frame already in progress when reset released
        if (rx_dv) begin
          if (armed_q && (rxd == 4'h5)) state_d = S_PREAMBLE;
          else                           state_d = S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rxd == 4'hD) begin
          state_d  = S_DATA;
          cnt_d    = '0;
          phase_d  = 1'b0;
          uni_ok_d = 1'b1;
          bc_ok_d  = 1'b1;
        end else if (rxd != 4'h5) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (!phase_q) begin
          lo_d    = rxd;
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          uni_ok_d = uni_ok_n;
          bc_ok_d  = bc_ok_n;
          if (byte_bad) begin
            state_d = S_DROP;
          end else begin
            if (cnt_q >= 6'd22 && cnt_q <= 6'd27) smac_d = {smac_q[39:0], rx_byte};
            if (cnt_q >= 6'd28 && cnt_q <= 6'd31) sip_d  = {sip_q[23:0], rx_byte};
            if (cnt_q == 6'd41) state_d = S_WAIT_END;
            else                cnt_d   = cnt_q + 6'd1;
          end
        end
      end
      S_WAIT_END: begin
        if (!rx_dv) begin
          if (tx_busy) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_PUBLISH;
            pc_mac_d = smac_q;
            pc_ip_d  = sip_q;
          end
        end
      end
      S_DROP: begin
        if (!rx_dv) state_d = S_IDLE;
      end
      S_PUBLISH: begin
        ena_d   = 1'b1;
        hits_d  = hits_q + 8'd1;
        state_d = rx_dv ? S_DROP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      lo_q     <= '0;
      uni_ok_q <= 1'b0;
      bc_ok_q  <= 1'b0;
      smac_q   <= '0;
      sip_q    <= '0;
      pc_mac_q <= '0;
      pc_ip_q  <= '0;
      ena_q    <= 1'b0;
      hits_q   <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      lo_q     <= lo_d;
      uni_ok_q <= uni_ok_d;
      bc_ok_q  <= bc_ok_d;
      smac_q   <= smac_d;
      sip_q    <= sip_d;
      pc_mac_q <= pc_mac_d;
      pc_ip_q  <= pc_ip_d;
      ena_q    <= ena_d;
      hits_q   <= hits_d;
      armed_q  <= armed_d;
    end
  end

  assign PC_MAC   = pc_mac_q;
  assign PC_IP    = pc_ip_q;
  assign ena      = ena_q;
  assign arp_hits = hits_q;

endmodule

// File: tb/tb_arp_request_parser.sv
// Directed bench for arp_request_parser: hand-built ARP frames sent nibble by
// nibble, outputs checked at the falling clock edge.
module tb_arp_request_parser;

  localparam logic [47:0] BM    = 48'h02AABBCCDDEE;
  localparam logic [31:0] BI    = 32'hC0A80164;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] FMAC  = 48'h02DEADBEEF01;
  localparam logic [47:0] A_MAC = 48'h001122334455;
  localparam logic [31:0] A_IP  = 32'hC0A8010A;
  localparam logic [47:0] B_MAC = 48'h0A0B0C0D0E0F;
  localparam logic [31:0] B_IP  = 32'h0A000005;

  logic        clock = 1'b0;
  logic        aclr_n, rx_dv, tx_busy;
  logic [3:0]  rxd;
  logic [47:0] PC_MAC;
  logic [31:0] PC_IP;
  logic        ena;
  logic [7:0]  arp_hits;

  int tests = 0;
  int fails = 0;
  logic [7:0] frm [0:63];

  arp_request_parser #(.ACCEPT_BROADCAST(1'b1)) dut (
    .clock(clock), .aclr_n(aclr_n), .rx_dv(rx_dv), .rxd(rxd),
    .BOARD_MAC(BM), .BOARD_IP(BI), .tx_busy(tx_busy),
    .PC_MAC(PC_MAC), .PC_IP(PC_IP), .ena(ena), .arp_hits(arp_hits)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                       input logic [15:0] oper, input logic [47:0] smac,
                       input logic [31:0] sip, input logic [31:0] tip);
    for (int i = 0; i < 64; i++) frm[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 6; i++) begin
      frm[i]      = dmac[47 - 8*i -: 8];
      frm[6 + i]  = smac[47 - 8*i -: 8];
      frm[22 + i] = smac[47 - 8*i -: 8];
    end
    frm[12] = etype[15:8]; frm[13] = etype[7:0];
    frm[14] = 8'h00; frm[15] = 8'h01; frm[16] = 8'h08; frm[17] = 8'h00;
    frm[18] = 8'h06; frm[19] = 8'h04;
    frm[20] = oper[15:8]; frm[21] = oper[7:0];
    for (int i = 0; i < 4; i++) begin
      frm[28 + i] = sip[31 - 8*i -: 8];
      frm[38 + i] = tip[31 - 8*i -: 8];
    end
  endtask

  task automatic nib(input logic [3:0] n);
    @(negedge clock);
    rx_dv = 1'b1;
    rxd   = n;
  endtask

  task automatic send_pre();
    for (int i = 0; i < 15; i++) nib(4'h5);
    nib(4'hD);
  endtask

  task automatic send_bytes(input int lo, input int hi);
    logic [7:0] b;
    for (int i = lo; i < hi; i++) begin
      b = frm[i];
      nib(b[3:0]);
      nib(b[7:4]);
    end
  endtask

  task automatic send(input int nbytes);
    send_pre();
    send_bytes(0, nbytes);
  endtask

  // Drop rx_dv and check the ena timing plus the published/held outputs
  task automatic end_frame(input string tag, input logic exp_ena, input logic [47:0] emac,
                           input logic [31:0] eip, input logic [7:0] ehits);
    @(negedge clock); rx_dv = 1'b0; rxd = 4'h0;
    @(negedge clock); chk({tag, "_ena_c1"}, 64'(ena), 64'(1'b0));
    @(negedge clock); chk({tag, "_ena_c2"}, 64'(ena), 64'(exp_ena));
    @(negedge clock); chk({tag, "_ena_c3"}, 64'(ena), 64'(1'b0));
    chk({tag, "_pc_mac"}, 64'(PC_MAC), 64'(emac));
    chk({tag, "_pc_ip"}, 64'(PC_IP), 64'(eip));
    chk({tag, "_hits"}, 64'(arp_hits), 64'(ehits));
    tx_busy = 1'b0;
  endtask

  initial begin
    aclr_n = 1'b0; rx_dv = 1'b0; rxd = 4'h0; tx_busy = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_pc_mac", 64'(PC_MAC), 64'h0);
    chk("rst_pc_ip", 64'(PC_IP), 64'h0);
    chk("rst_ena", 64'(ena), 64'h0);
    chk("rst_hits", 64'(arp_hits), 64'h0);
    aclr_n = 1'b1;
    repeat (2) @(negedge clock);

    // Broadcast request to our IP
    build(BCAST, 16'h0806, 16'h0001, A_MAC, A_IP, BI);
    send(60); end_frame("bcast_ok", 1'b1, A_MAC, A_IP, 8'd1);

    // Wrong target IP
    build(BCAST, 16'h0806, 16'h0001, B_MAC, B_IP, 32'hC0A80163);
    send(60); end_frame("bad_tip", 1'b0, A_MAC, A_IP, 8'd1);

    // Reply opcode, foreign unicast dest, IPv4 ethertype
    build(BCAST, 16'h0806, 16'h0002, B_MAC, B_IP, BI);
    send(60); end_frame("oper_reply", 1'b0, A_MAC, A_IP, 8'd1);
    build(FMAC, 16'h0806, 16'h0001, B_MAC, B_IP, BI);
    send(60); end_frame("foreign_dmac", 1'b0, A_MAC, A_IP, 8'd1);
    build(BCAST, 16'h0800, 16'h0001, B_MAC, B_IP, BI);
    send(60); end_frame("etype_ip", 1'b0, A_MAC, A_IP, 8'd1);

    // Unicast to our MAC, exactly 42 bytes
    build(BM, 16'h0806, 16'h0001, B_MAC, B_IP, BI);
    send(42); end_frame("unicast_ok", 1'b1, B_MAC, B_IP, 8'd2);

    // Truncated after byte 30, then a normal frame
    build(BCAST, 16'h0806, 16'h0001, A_MAC, A_IP, BI);
    send(31); end_frame("trunc", 1'b0, B_MAC, B_IP, 8'd2);
    send(60); end_frame("after_trunc", 1'b1, A_MAC, A_IP, 8'd3);

    // Transmitter busy at frame end
    build(BCAST, 16'h0806, 16'h0001, B_MAC, B_IP, BI);
    tx_busy = 1'b1;
    send(60); end_frame("tx_busy", 1'b0, A_MAC, A_IP, 8'd3);

    // New frame begins while PUBLISH: that frame must be ignored
    send(42);
    @(negedge clock); rx_dv = 1'b0; rxd = 4'h0;
    @(negedge clock); chk("coll_ena_c1", 64'(ena), 64'h0);
    rx_dv = 1'b1; rxd = 4'h5;
    @(negedge clock); chk("coll_ena_c2", 64'(ena), 64'h1);
    chk("coll_hits", 64'(arp_hits), 64'd4);
    chk("coll_pc_mac", 64'(PC_MAC), 64'(B_MAC));
    build(BCAST, 16'h0806, 16'h0001, A_MAC, A_IP, BI);
    send(42); end_frame("coll_ignored", 1'b0, B_MAC, B_IP, 8'd4);

    // Reset at byte 20, rest of that frame ignored, next frame accepted
    send(20);
    @(negedge clock); aclr_n = 1'b0;
    #1;
    chk("midrst_pc_mac", 64'(PC_MAC), 64'h0);
    chk("midrst_pc_ip", 64'(PC_IP), 64'h0);
    chk("midrst_ena", 64'(ena), 64'h0);
    chk("midrst_hits", 64'(arp_hits), 64'h0);
    @(negedge clock); aclr_n = 1'b1;
    send_bytes(20, 60);
    end_frame("midrst_tail", 1'b0, 48'h0, 32'h0, 8'd0);
    build(BCAST, 16'h0806, 16'h0001, B_MAC, B_IP, BI);
    send(42); end_frame("after_rst", 1'b1, B_MAC, B_IP, 8'd1);

    // 255 more accepted requests wrap the hit counter to zero
    build(BCAST, 16'h0806, 16'h0001, A_MAC, A_IP, BI);
    for (int k = 0; k < 255; k++) begin
      send(42);
      end_frame("wrap_seq", 1'b1, A_MAC, A_IP, 8'(2 + k));
    end
    chk("wrap_zero", 64'(arp_hits), 64'h0);

    // Reset during PUBLISH suppresses the pulse
    send(42);
    @(negedge clock); rx_dv = 1'b0; rxd = 4'h0;
    @(negedge clock); aclr_n = 1'b0;
    #1 chk("pubrst_ena0", 64'(ena), 64'h0);
    @(negedge clock); aclr_n = 1'b1;
    chk("pubrst_ena1", 64'(ena), 64'h0);
    @(negedge clock);
    chk("pubrst_ena2", 64'(ena), 64'h0);
    chk("pubrst_hits", 64'(arp_hits), 64'h0);
    chk("pubrst_pc_mac", 64'(PC_MAC), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
